// File: rtl/agu_banked.sv
// agu_banked: banked pointer registers with byte-serial stepping; define AGU_BANKED_ARITH_EN to build STEP/INC/DEC
module agu_banked #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BYTES = 2,
  parameter int CHANNELS = 4,
  localparam int ADDR_WIDTH = DATA_WIDTH * ADDR_BYTES,
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1,
  localparam int BW = ADDR_BYTES > 1 ? $clog2(ADDR_BYTES) : 1
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic [2:0]            op_i,
  input  logic [CW-1:0]         channel_select_i,
  input  logic [BW-1:0]         byte_select_i,
  input  logic [DATA_WIDTH-1:0] data_in_i,
  input  logic [ADDR_WIDTH-1:0] address_in_i,
  output logic [ADDR_WIDTH-1:0] address_out_o,
  output logic [DATA_WIDTH-1:0] data_out_o,
  output logic                  busy_o,
  output logic                  wrap_o
);
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STEP  = 3'd3;
  localparam logic [2:0] OP_INC   = 3'd4;
  localparam logic [2:0] OP_DEC   = 3'd5;
  logic [ADDR_WIDTH-1:0] regs_q [CHANNELS];
  logic [ADDR_WIDTH-1:0] regs_d [CHANNELS];
  logic ch_ok, byte_ok, idle;
  assign ch_ok   = int'(channel_select_i) < CHANNELS;
  assign byte_ok = int'(byte_select_i) < ADDR_BYTES;
`ifdef AGU_BANKED_ARITH_EN
  typedef enum logic {IDLE, ADD} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] k_q, k_d;
  logic [CW-1:0] ch_q, ch_d;
  logic [ADDR_WIDTH-1:0] shadow_q, shadow_d, operand_q, operand_d, shadow_nx;
  logic carry_q, carry_d, wrap_q, wrap_d, commit, arith_go;
  logic [DATA_WIDTH:0] sum;
  assign idle     = state_q == IDLE;
  assign arith_go = idle && ch_ok && (op_i == OP_STEP || op_i == OP_INC || op_i == OP_DEC);
  assign sum = {1'b0, shadow_q[k_q*DATA_WIDTH +: DATA_WIDTH]} + {1'b0, operand_q[k_q*DATA_WIDTH +: DATA_WIDTH]}
             + {{DATA_WIDTH{1'b0}}, carry_q};
  assign busy_o = state_q == ADD;
  assign wrap_o = wrap_q;
  // shadow with the current byte's sum merged in; this is what gets committed on the last byte
  always_comb begin
    shadow_nx = shadow_q;
    shadow_nx[k_q*DATA_WIDTH +: DATA_WIDTH] = sum[DATA_WIDTH-1:0];
  end
  // serial adder control: latch operands in IDLE, one byte per cycle in ADD, commit on the last byte
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    carry_d = carry_q;
    ch_d = ch_q;
    shadow_d = shadow_q;
    operand_d = operand_q;
    wrap_d = wrap_q;
    commit = 1'b0;
    if (arith_go) begin
      state_d = ADD;
      k_d = '0;
      carry_d = 1'b0;
      ch_d = channel_select_i;
      shadow_d = regs_q[channel_select_i];
      operand_d = op_i == OP_STEP ? ADDR_WIDTH'($signed(data_in_i)) : op_i == OP_INC ? ADDR_WIDTH'(1) : '1;
    end else if (state_q == ADD) begin
      shadow_d = shadow_nx;
      carry_d = sum[DATA_WIDTH];
      k_d = k_q + 1'b1;
      if (k_q == BW'(ADDR_BYTES - 1)) begin
        commit = 1'b1;
        wrap_d = sum[DATA_WIDTH] ^ operand_q[ADDR_WIDTH-1];
        state_d = IDLE;
      end
    end
  end
  // arithmetic state registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      k_q <= '0;
      carry_q <= 1'b0;
      ch_q <= '0;
      shadow_q <= '0;
      operand_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      carry_q <= carry_d;
      ch_q <= ch_d;
      shadow_q <= shadow_d;
      operand_q <= operand_d;
      wrap_q <= wrap_d;
    end
  end
`else
  assign idle   = 1'b1;
  assign busy_o = 1'b0;
  assign wrap_o = 1'b0;
`endif
  // channel register updates: byte writes, whole loads and arithmetic commits
  always_comb begin
    regs_d = regs_q;
    if (idle && ch_ok && byte_ok && op_i == OP_WRITE)
      regs_d[channel_select_i][byte_select_i*DATA_WIDTH +: DATA_WIDTH] = data_in_i;
    if (idle && ch_ok && op_i == OP_LOAD)
      regs_d[channel_select_i] = address_in_i;
`ifdef AGU_BANKED_ARITH_EN
    if (commit)
      regs_d[ch_q] = shadow_nx;
`endif
  end
  // channel register bank
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  end
  assign address_out_o = ch_ok ? regs_q[channel_select_i] : '0;
  assign data_out_o    = byte_ok ? address_out_o[byte_select_i*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_agu_banked.sv
// tb_agu_banked: scoreboard bench for agu_banked, expectations adapt to AGU_BANKED_ARITH_EN
module tb_agu_banked;
`ifdef AGU_BANKED_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] op = '0;
  logic [1:0] cs = '0;
  logic bsel = 1'b0;
  logic [7:0] din = '0;
  logic [15:0] ain = '0, addr_out;
  logic [7:0] dout;
  logic busy, wrap;
  typedef struct {string tag; logic [15:0] val;} exp_t;
  exp_t sb[$];
  int n_chk = 0, n_fail = 0;
  logic [15:0] mdl [4];
  logic mwrap;
  agu_banked dut (
    .clock_i(clk), .reset_i(rst), .op_i(op), .channel_select_i(cs), .byte_select_i(bsel),
    .data_in_i(din), .address_in_i(ain), .address_out_o(addr_out), .data_out_o(dout),
    .busy_o(busy), .wrap_o(wrap)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic expect_val(input string tag, input logic [15:0] v);
    sb.push_back('{tag, v});
  endtask
  task automatic pop_check(input logic [15:0] obs);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %h expected none", obs);
    end else begin
      e = sb.pop_front();
      check(e.tag, obs, e.val);
    end
  endtask
  task automatic model_arith(input int ch, input int delta);
    int s;
    s = int'(mdl[ch]) + delta;
    mdl[ch] = s[15:0];
    mwrap = (s < 0) || (s > 65535);
  endtask
  task automatic apply(input logic [2:0] o, input int ch, input int bs, input logic [7:0] d, input logic [15:0] a);
    logic [15:0] old;
    bit ar;
    int n;
    old = mdl[ch];
    n = 0;
    ar = ARITH && (o == 3'd3 || o == 3'd4 || o == 3'd5);
    if (o == 3'd1) mdl[ch][bs*8 +: 8] = d;
    if (o == 3'd2) mdl[ch] = a;
    if (ar) model_arith(ch, o == 3'd3 ? int'($signed(d)) : o == 3'd4 ? 1 : -1);
    expect_val("busy_cycles", ar ? 16'd2 : 16'd0);
    expect_val("addr_after_op", mdl[ch]);
    expect_val("wrap_after_op", {15'b0, mwrap});
    @(negedge clk);
    op = o; cs = 2'(ch); bsel = bs[0]; din = d; ain = a;
    @(negedge clk);
    op = 3'd0;
    while (busy && n < 10) begin
      check("hold_old_value", addr_out, old);
      n++;
      @(negedge clk);
    end
    pop_check(16'(n));
    pop_check(addr_out);
    pop_check({15'b0, wrap});
  endtask
  task automatic rd(input int ch, input int bs);
    expect_val("read_addr", mdl[ch]);
    expect_val("read_byte", {8'h00, mdl[ch][bs*8 +: 8]});
    @(negedge clk);
    cs = 2'(ch); bsel = bs[0];
    #1;
    pop_check(addr_out);
    pop_check({8'h00, dout});
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("busy_timeout", {15'b0, busy}, 16'h0);
  endtask
  initial begin
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    mwrap = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", {15'b0, busy}, 16'h0);
    check("reset_wrap", {15'b0, wrap}, 16'h0);
    check("reset_addr", addr_out, 16'h0);
    rst = 1'b0;
    apply(3'd1, 1, 0, 8'h64, 16'h0);
    apply(3'd1, 1, 1, 8'h40, 16'h0);
    for (int c = 0; c < 4; c++) rd(c, 0);
    check("ch1_composed", mdl[1], 16'h4064);
    apply(3'd2, 2, 0, 8'h00, 16'h7A0E);
    rd(2, 0);
    rd(2, 1);
    apply(3'd2, 0, 0, 8'h00, 16'hFFFF);
    apply(3'd4, 0, 0, 8'h00, 16'h0);
    apply(3'd2, 3, 0, 8'h00, 16'h4E20);
    apply(3'd3, 3, 0, 8'hFE, 16'h0);
    apply(3'd2, 3, 0, 8'h00, 16'h0000);
    apply(3'd5, 3, 0, 8'h00, 16'h0);
    apply(3'd3, 2, 0, 8'h7F, 16'h0);
    apply(3'd2, 2, 0, 8'h00, 16'hFF90);
    apply(3'd3, 2, 0, 8'h70, 16'h0);
    @(negedge clk);
    op = 3'd3; cs = 2'd0; din = 8'h05;
    @(negedge clk);
    check("busy_rise", {15'b0, busy}, {15'b0, ARITH});
    op = 3'd4; cs = 2'd1;
    @(negedge clk);
    op = 3'd0; cs = 2'd0;
    wait_idle();
    if (ARITH) model_arith(0, 5);
    rd(0, 0);
    rd(1, 0);
    check("wrap_after_overlap", {15'b0, wrap}, {15'b0, mwrap});
    @(negedge clk);
    op = 3'd3; cs = 2'd2; din = 8'h01;
    @(negedge clk);
    op = 3'd0;
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {15'b0, busy}, 16'h0);
    check("abort_wrap", {15'b0, wrap}, 16'h0);
    for (int i = 0; i < 4; i++) mdl[i] = '0;
    mwrap = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) rd(c, 1);
    apply(3'd2, 0, 0, 8'h00, 16'h1234);
    apply(3'd4, 0, 0, 8'h00, 16'h0);
    rd(0, 0);
    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/agu_banked.md
# agu_banked

Parametrised, multi-channel address generation unit for the 8-bit CPU datapath. It holds CHANNELS address registers of ADDR_BYTES × DATA_WIDTH bits each. Each register can be composed byte-by-byte from the data bus, loaded whole from the address bus, read back byte-wise, or stepped by a signed byte through a byte-serial carry adder. It sits between the register file/data bus and the memory address bus, and supplies pointer registers with post-increment, decrement and offset stepping.

## Interface
- DATA_WIDTH, 8, data bus width and byte size.
- ADDR_BYTES, 2, bytes per address; ADDR_WIDTH = DATA_WIDTH*ADDR_BYTES.
- CHANNELS, 4, number of address registers.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- op  in  3  operation code: 0 NOP, 1 WRITE_BYTE, 2 LOAD_ADDR, 3 STEP, 4 INC, 5 DEC, 6–7 NOP.
- channel_select  in  $clog2(CHANNELS)  target channel for op; also selects the channel shown on the outputs.
- byte_select  in  $clog2(ADDR_BYTES)  byte index (0 = low) for WRITE_BYTE and data_out.
- data_in  in  DATA_WIDTH  byte for WRITE_BYTE; signed step for STEP.
- address_in  in  ADDR_WIDTH  full address for LOAD_ADDR.
- address_out  out  ADDR_WIDTH  committed register of channel_select (combinational mux of state).
- data_out  out  DATA_WIDTH  byte byte_select of address_out.
- busy  out  1  high while a serial arithmetic op is in flight.
- wrap  out  1  wrap flag from the last completed arithmetic op.

## Operation
- Reset values: all channel registers 0, busy 0, wrap 0, FSM in IDLE. address_out and data_out therefore read 0.
- op is sampled only when busy = 0. Any op presented while busy = 1 is ignored; ops are not queued.
- WRITE_BYTE: sets byte byte_select of channel channel_select to data_in. The other bytes are unchanged.
- LOAD_ADDR: sets channel channel_select to address_in.
- Out-of-range channel_select or byte_select: writes and ops are ignored, and address_out/data_out read 0.
- Arithmetic ops are STEP, INC and DEC. The operand is sign_extend(data_in) for STEP, +1 for INC and all-ones (−1) for DEC. Arithmetic is modulo 2^ADDR_WIDTH.
- FSM IDLE: on an accepted arithmetic op, latch the channel index, the operand and the current value into a shadow; clear the byte counter and carry; go to ADD.
- FSM ADD: each cycle adds byte k of shadow, byte k of operand and the carry, writes the sum back to shadow byte k, and increments k. At k = ADDR_BYTES−1 it commits shadow to the channel, updates wrap and returns to IDLE.
- wrap = final carry-out for a non-negative operand; wrap = NOT final carry-out for a negative operand. That is, wrap = 1 exactly when the result wrapped past 0 or past all-ones.
- wrap holds its value until the next arithmetic op completes. WRITE_BYTE and LOAD_ADDR do not change it.
- The stepped channel shows its old value on address_out until commit; no partial values are visible.
- channel_select may change freely while busy. The outputs follow it; the in-flight op uses the latched channel.

## Timing
- WRITE_BYTE/LOAD_ADDR accepted at edge N are visible on address_out after edge N.
- Arithmetic op accepted at edge N: busy rises after edge N. Byte k is computed at edge N+1+k. The result is committed and busy falls after edge N+ADDR_BYTES, giving a latency of ADDR_BYTES cycles.
- A new op can be accepted at edge N+ADDR_BYTES+1, because busy is sampled low before that edge.
- Reset mid-operation aborts the op: the shadow is discarded, all channels are cleared, and busy, wrap and FSM state are reset asynchronously.

## Configuration
- AGU_BANKED_ARITH_EN defined: STEP/INC/DEC, the FSM, the shadow and the adder are compiled in as above.
- AGU_BANKED_ARITH_EN undefined: op codes 3–5 act as NOP, busy is tied 0, wrap is tied 0, and no adder or shadow logic is built. WRITE_BYTE and LOAD_ADDR are unchanged.

## Test plan
All scenarios use the defaults DATA_WIDTH = 8, ADDR_BYTES = 2, CHANNELS = 4.
- Reset, then WRITE_BYTE ch1 byte0 = 0x64, byte1 = 0x40 -> ch1 address_out = 0x4064; ch0, ch2 and ch3 read 0x0000.
- LOAD_ADDR ch2 = 31246 (0x7A0E) -> data_out reads 0x0E with byte_select 0 and 0x7A with byte_select 1; wrap stays 0.
- ch0 = 0xFFFF, INC -> busy high for exactly 2 cycles and address_out = 0xFFFF while busy; then 0x0000 with wrap = 1.
- ch3 = 20000 (0x4E20), STEP with data_in = 0xFE -> 0x4E1E and wrap = 0. Then ch3 = 0x0000, DEC -> 0xFFFF and wrap = 1.
- INC issued on ch1 while a STEP is busy on ch0 -> ch1 is unchanged. Reset asserted one cycle into a STEP -> all channels 0, busy 0, wrap 0.
- With AGU_BANKED_ARITH_EN undefined: INC on ch0 = 0x1234 -> value stays 0x1234, busy never asserts.
